// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem integer-writeback path.
package fpu_ss_pkg;

  localparam int unsigned FPU_SS_RD_W   = 5;
  localparam int unsigned FPU_SS_ID_W   = 4;
  localparam int unsigned FPU_SS_DATA_W = 32;

  typedef struct packed {
    logic [FPU_SS_ID_W-1:0]   id;
    logic [FPU_SS_RD_W-1:0]   rd;
    logic [FPU_SS_DATA_W-1:0] data;
  } int_wb_t;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// Generic synchronous FIFO with a typed entry and first-word-fall-through head.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module fpu_ss_wb_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic               w_push;
  logic               w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign count_o = r_count;
  assign data_o  = r_mem[r_rptr];

  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/fpu_ss_int_wb.sv
// Integer-writeback transmitter: buffers CSR results, round-robins them against
// the FPU integer-result port and drives one registered result channel to the core.
module fpu_ss_int_wb
  import fpu_ss_pkg::*;
#(
  parameter int unsigned CSR_FIFO_DEPTH = 2,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   csr_wb_i,
  input  logic [FPU_SS_RD_W-1:0] csr_wb_addr_i,
  input  logic [ID_WIDTH-1:0]    csr_wb_id_i,
  input  logic [DATA_WIDTH-1:0]  csr_rdata_i,
  output logic                   csr_afull_o,
  input  logic                   fpu_int_valid_i,
  output logic                   fpu_int_ready_o,
  input  logic [FPU_SS_RD_W-1:0] fpu_int_rd_i,
  input  logic [ID_WIDTH-1:0]    fpu_int_id_i,
  input  logic [DATA_WIDTH-1:0]  fpu_int_data_i,
  output logic                   x_result_valid_o,
  input  logic                   x_result_ready_i,
  output logic [ID_WIDTH-1:0]    x_result_id_o,
  output logic [FPU_SS_RD_W-1:0] x_result_rd_o,
  output logic [DATA_WIDTH-1:0]  x_result_data_o,
  output logic                   x_result_we_o,
  output logic                   overflow_o
);

  localparam int unsigned CNT_W = $clog2(CSR_FIFO_DEPTH) + 1;

  int_wb_t    w_csr_in;
  int_wb_t    w_csr_head;
  int_wb_t    w_fpu_in;
  int_wb_t    r_out;
  logic [CNT_W-1:0] w_csr_count;
  logic       w_csr_full;
  logic       w_csr_empty;
  logic       r_valid;
  logic       r_we;
  logic       r_rr;
  logic       r_ovf;
  logic       w_load;
  logic       w_csr_pend;
  logic       w_fpu_pend;
  logic       w_gnt_csr;
  logic       w_gnt_fpu;

  assign w_csr_in = '{id:   FPU_SS_ID_W'(csr_wb_id_i),
                      rd:   csr_wb_addr_i,
                      data: FPU_SS_DATA_W'(csr_rdata_i)};
  assign w_fpu_in = '{id:   FPU_SS_ID_W'(fpu_int_id_i),
                      rd:   fpu_int_rd_i,
                      data: FPU_SS_DATA_W'(fpu_int_data_i)};

  fpu_ss_wb_fifo #(
    .T     (int_wb_t),
    .DEPTH (CSR_FIFO_DEPTH)
  ) i_csr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (csr_wb_i),
    .data_i  (w_csr_in),
    .pop_i   (w_gnt_csr),
    .data_o  (w_csr_head),
    .count_o (w_csr_count),
    .full_o  (w_csr_full),
    .empty_o (w_csr_empty)
  );

  // The output stage refills whenever it is empty or being drained this cycle.
  assign w_load     = !r_valid || x_result_ready_i;
  assign w_csr_pend = !w_csr_empty;
  assign w_fpu_pend = fpu_int_valid_i;
  assign w_gnt_csr  = w_load && w_csr_pend && (!w_fpu_pend || !r_rr);
  assign w_gnt_fpu  = w_load && w_fpu_pend && (!w_csr_pend || r_rr);

  assign fpu_int_ready_o = rst_ni && w_gnt_fpu;
  // Threshold one below full leaves room for the pulse of an already-issued CSR op.
  assign csr_afull_o     = (w_csr_count >= CNT_W'(CSR_FIFO_DEPTH - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_out   <= '0;
      r_rr    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        if (w_gnt_csr) begin
          r_out   <= w_csr_head;
          r_valid <= 1'b1;
          r_we    <= 1'b1;
        end else if (w_gnt_fpu) begin
          r_out   <= w_fpu_in;
          r_valid <= 1'b1;
          r_we    <= 1'b1;
        end else begin
          r_valid <= 1'b0;
          r_we    <= 1'b0;
        end
        if (w_csr_pend && w_fpu_pend) r_rr <= !r_rr;
      end
      if (csr_wb_i && w_csr_full && !w_gnt_csr) r_ovf <= 1'b1;
    end
  end

  assign x_result_valid_o = r_valid;
  assign x_result_we_o    = r_we;
  assign x_result_id_o    = ID_WIDTH'(r_out.id);
  assign x_result_rd_o    = r_out.rd;
  assign x_result_data_o  = DATA_WIDTH'(r_out.data);
  assign overflow_o       = r_ovf;

endmodule

// File: tb/tb_fpu_ss_int_wb.sv
// Self-checking bench for fpu_ss_int_wb: directed vector table, hand sequences
// for the FIFO corner cases and a randomized run against a queue-based model.
module tb_fpu_ss_int_wb;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_ni;
  logic        csr_wb_i;
  logic [4:0]  csr_wb_addr_i;
  logic [3:0]  csr_wb_id_i;
  logic [31:0] csr_rdata_i;
  logic        csr_afull_o;
  logic        fpu_int_valid_i;
  logic        fpu_int_ready_o;
  logic [4:0]  fpu_int_rd_i;
  logic [3:0]  fpu_int_id_i;
  logic [31:0] fpu_int_data_i;
  logic        x_result_valid_o;
  logic        x_result_ready_i;
  logic [3:0]  x_result_id_o;
  logic [4:0]  x_result_rd_o;
  logic [31:0] x_result_data_o;
  logic        x_result_we_o;
  logic        overflow_o;

  fpu_ss_int_wb #(
    .CSR_FIFO_DEPTH (DEPTH),
    .ID_WIDTH       (4),
    .DATA_WIDTH     (32)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .csr_wb_i         (csr_wb_i),
    .csr_wb_addr_i    (csr_wb_addr_i),
    .csr_wb_id_i      (csr_wb_id_i),
    .csr_rdata_i      (csr_rdata_i),
    .csr_afull_o      (csr_afull_o),
    .fpu_int_valid_i  (fpu_int_valid_i),
    .fpu_int_ready_o  (fpu_int_ready_o),
    .fpu_int_rd_i     (fpu_int_rd_i),
    .fpu_int_id_i     (fpu_int_id_i),
    .fpu_int_data_i   (fpu_int_data_i),
    .x_result_valid_o (x_result_valid_o),
    .x_result_ready_i (x_result_ready_i),
    .x_result_id_o    (x_result_id_o),
    .x_result_rd_o    (x_result_rd_o),
    .x_result_data_o  (x_result_data_o),
    .x_result_we_o    (x_result_we_o),
    .overflow_o       (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  typedef struct {
    logic       csr;
    logic [3:0] cid;
    logic       fv;
    logic [3:0] fid;
    logic       rdy;
    logic       e_fr;
    logic       e_v;
    logic [3:0] e_id;
  } vec_t;

  // Reference model: queue of buffered CSR results plus the result seen by the core.
  res_t        q_csr[$];
  int          dlv[$];
  logic        m_valid, m_we, m_fav_fpu, m_ovf, m_last_gf, s_fready;
  logic [3:0]  m_id;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          checks;
  int          errors;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_csr.delete();
    dlv.delete();
    m_valid = 0; m_we = 0; m_fav_fpu = 0; m_ovf = 0; m_last_gf = 0;
    m_id = 0; m_rd = 0; m_data = 0;
  endtask

  task automatic set_idle();
    csr_wb_i = 0; csr_wb_addr_i = 0; csr_wb_id_i = 0; csr_rdata_i = 0;
    fpu_int_valid_i = 0; fpu_int_rd_i = 0; fpu_int_id_i = 0; fpu_int_data_i = 0;
    x_result_ready_i = 0;
  endtask

  task automatic set_csr(input logic v, input logic [3:0] id);
    csr_wb_i = v; csr_wb_id_i = id;
    csr_wb_addr_i = 5'(id) + 5'd8;
    csr_rdata_i = 32'hC000_0000 | 32'(id);
  endtask

  task automatic set_fpu(input logic v, input logic [3:0] id);
    fpu_int_valid_i = v; fpu_int_id_i = id;
    fpu_int_rd_i = 5'(id) + 5'd16;
    fpu_int_data_i = 32'hF000_0000 | 32'(id);
  endtask

  task automatic do_reset();
    rst_ni = 0;
    #1;
    chk("rst_valid", x_result_valid_o, 0);
    chk("rst_we", x_result_we_o, 0);
    chk("rst_id", x_result_id_o, 0);
    chk("rst_rd", x_result_rd_o, 0);
    chk("rst_data", x_result_data_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_afull", csr_afull_o, 0);
    chk("rst_fready", fpu_int_ready_o, 0);
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1;
  endtask

  // One clock: check combinational outputs before the edge, advance the model, check registers after.
  task automatic cycle();
    logic ld, cp, fp, gc, gf, full_b;
    res_t r;
    #1;
    ld = !m_valid || x_result_ready_i;
    cp = q_csr.size() != 0;
    fp = fpu_int_valid_i;
    gc = ld && cp && (!fp || !m_fav_fpu);
    gf = ld && fp && (!cp || m_fav_fpu);
    s_fready  = fpu_int_ready_o;
    m_last_gf = gf;
    chk("fpu_ready", fpu_int_ready_o, gf);
    chk("csr_afull", csr_afull_o, q_csr.size() >= DEPTH - 1);
    if (x_result_valid_o && x_result_ready_i) begin
      dlv.push_back(int'(x_result_id_o));
      $display("xfer id=%0d rd=%0d data=%h we=%0b", x_result_id_o, x_result_rd_o,
               x_result_data_o, x_result_we_o);
    end
    full_b = q_csr.size() == DEPTH;
    if (ld) begin
      if (gc) begin
        r = q_csr.pop_front();
        m_id = r.id; m_rd = r.rd; m_data = r.data; m_valid = 1; m_we = 1;
      end else if (gf) begin
        m_id = fpu_int_id_i; m_rd = fpu_int_rd_i; m_data = fpu_int_data_i;
        m_valid = 1; m_we = 1;
      end else begin
        m_valid = 0; m_we = 0;
      end
      if (cp && fp) m_fav_fpu = !m_fav_fpu;
    end
    if (csr_wb_i) begin
      if (!full_b || gc) q_csr.push_back('{csr_wb_id_i, csr_wb_addr_i, csr_rdata_i});
      else m_ovf = 1;
    end
    @(posedge clk);
    #1;
    chk("x_valid", x_result_valid_o, m_valid);
    chk("x_we", x_result_we_o, m_we);
    chk("x_id", x_result_id_o, m_id);
    chk("x_rd", x_result_rd_o, m_rd);
    chk("x_data", x_result_data_o, m_data);
    chk("overflow", overflow_o, m_ovf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    //            csr cid  fv fid  rdy e_fr e_v e_id
    tbl[0] = '{1, 4'd1, 0, 4'd0,  0, 0, 0, 4'd0};
    tbl[1] = '{1, 4'd2, 0, 4'd0,  0, 0, 1, 4'd1};
    tbl[2] = '{1, 4'd3, 0, 4'd0,  0, 0, 1, 4'd1};
    tbl[3] = '{0, 4'd0, 1, 4'd9,  1, 0, 1, 4'd2};
    tbl[4] = '{0, 4'd0, 1, 4'd9,  1, 1, 1, 4'd9};
    tbl[5] = '{0, 4'd0, 1, 4'd10, 1, 0, 1, 4'd3};
    tbl[6] = '{0, 4'd0, 1, 4'd10, 1, 1, 1, 4'd10};
    tbl[7] = '{0, 4'd0, 0, 4'd0,  1, 0, 0, 4'd10};

    set_idle();
    rst_ni = 1;
    #2;
    do_reset();

    // CSR only: pulse -> valid two edges later
    set_csr(1, 4'd5);
    csr_wb_addr_i = 5'd10; csr_rdata_i = 32'h0000_00E0;
    x_result_ready_i = 1;
    cycle();
    chk("csr_lat_early", x_result_valid_o, 0);
    set_csr(0, 4'd0);
    cycle();
    chk("csr_valid", x_result_valid_o, 1);
    chk("csr_id", x_result_id_o, 5);
    chk("csr_rd", x_result_rd_o, 10);
    chk("csr_data", x_result_data_o, 32'h0000_00E0);
    chk("csr_we", x_result_we_o, 1);
    cycle();
    chk("csr_done", x_result_valid_o, 0);
    chk("csr_empty_afull", csr_afull_o, 0);

    // FPU under backpressure
    do_reset();
    fpu_int_valid_i = 1; fpu_int_id_i = 4'd2; fpu_int_rd_i = 5'd7; fpu_int_data_i = 32'hDEADBEEF;
    cycle();
    chk("bp_fready_load", s_fready, 1);
    set_fpu(1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_hold_id", x_result_id_o, 2);
      chk("bp_hold_data", x_result_data_o, 32'hDEADBEEF);
      chk("bp_fready_stall", fpu_int_ready_o, 0);
    end
    x_result_ready_i = 1;
    cycle();
    chk("bp_next_id", x_result_id_o, 3);
    set_fpu(0, 4'd0);
    cycle();
    chk("bp_once", dlv.size(), 2);
    chk("bp_first", dlv[0], 2);

    // Contention table: alternating grants
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_csr(tbl[i].csr, tbl[i].cid);
      set_fpu(tbl[i].fv, tbl[i].fid);
      x_result_ready_i = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d_fready", i), s_fready, tbl[i].e_fr);
      chk($sformatf("tbl%0d_valid", i), x_result_valid_o, tbl[i].e_v);
      chk($sformatf("tbl%0d_id", i), x_result_id_o, tbl[i].e_id);
    end

    // Almost full and overflow
    do_reset();
    set_fpu(1, 4'd12);
    cycle();
    set_fpu(0, 4'd0);
    set_csr(1, 4'd1);
    cycle();
    chk("af_afull", csr_afull_o, 1);
    set_csr(1, 4'd2);
    cycle();
    chk("af_no_ovf", overflow_o, 0);
    set_csr(1, 4'd3);
    cycle();
    chk("af_ovf", overflow_o, 1);
    set_csr(0, 4'd0);
    x_result_ready_i = 1;
    repeat (5) cycle();
    chk("af_count", dlv.size(), 3);
    if (dlv.size() == 3) begin
      chk("af_d0", dlv[0], 12);
      chk("af_d1", dlv[1], 1);
      chk("af_d2", dlv[2], 2);
    end
    chk("af_ovf_sticky", overflow_o, 1);

    // Push and pop at full every cycle
    do_reset();
    set_fpu(1, 4'd12);
    cycle();
    set_fpu(0, 4'd0);
    set_csr(1, 4'd1);
    cycle();
    set_csr(1, 4'd2);
    cycle();
    x_result_ready_i = 1;
    for (int i = 3; i <= 8; i++) begin
      set_csr(1, 4'(i));
      cycle();
      chk("pp_afull", csr_afull_o, 1);
      chk("pp_no_ovf", overflow_o, 0);
    end
    set_csr(0, 4'd0);
    repeat (4) cycle();
    chk("pp_count", dlv.size(), 9);
    if (dlv.size() == 9) begin
      chk("pp_d0", dlv[0], 12);
      for (int i = 1; i < 9; i++) chk($sformatf("pp_d%0d", i), dlv[i], i);
    end

    // Reset with the output valid and one entry buffered
    do_reset();
    set_fpu(1, 4'd12);
    cycle();
    set_fpu(0, 4'd0);
    set_csr(1, 4'd4);
    cycle();
    set_csr(0, 4'd0);
    chk("mr_pre_valid", x_result_valid_o, 1);
    chk("mr_pre_afull", csr_afull_o, 1);
    do_reset();
    x_result_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mr_no_stale", x_result_valid_o, 0);
    end
    chk("mr_dlv", dlv.size(), 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!fpu_int_valid_i || m_last_gf) begin
        fpu_int_valid_i = $urandom_range(0, 99) < 55;
        fpu_int_id_i    = 4'($urandom);
        fpu_int_rd_i    = 5'($urandom);
        fpu_int_data_i  = $urandom;
      end
      csr_wb_i      = ($urandom_range(0, 99) < 35) && (!csr_afull_o || $urandom_range(0, 9) == 0);
      csr_wb_id_i   = 4'($urandom);
      csr_wb_addr_i = 5'($urandom);
      csr_rdata_i   = $urandom;
      x_result_ready_i = $urandom_range(0, 99) < 65;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_ss_int_wb.md
Name: fpu_ss_int_wb

Overview:
- Transmit side of the FPU subsystem's integer-writeback path.
- Collects results destined for the core's integer register file from two producers:
  - the FP CSR unit, which emits a single-cycle, non-stallable writeback pulse;
  - the FPU integer-result port (compares, classify, FP-to-int conversions and moves), which uses valid/ready.
- Buffers CSR results in a small FIFO, arbitrates round-robin, and drives one registered valid/ready result channel to the core.

Parameters:
- CSR_FIFO_DEPTH, 2: CSR result FIFO entries (power of two, >=2).
- ID_WIDTH, 4: instruction ID width.
- DATA_WIDTH, 32: integer result width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_wb_i  in  1  CSR writeback pulse, one cycle per result, never stalls
- csr_wb_addr_i  in  5  CSR destination rd
- csr_wb_id_i  in  ID_WIDTH  CSR instruction ID
- csr_rdata_i  in  DATA_WIDTH  CSR read data
- csr_afull_o  out  1  FIFO almost full; upstream must not pop a new CSR instruction while high
- fpu_int_valid_i  in  1  FPU integer result valid
- fpu_int_ready_o  out  1  FPU integer result accepted
- fpu_int_rd_i  in  5  FPU destination rd
- fpu_int_id_i  in  ID_WIDTH  FPU instruction ID
- fpu_int_data_i  in  DATA_WIDTH  FPU result
- x_result_valid_o  out  1  result to core valid
- x_result_ready_i  in  1  core accepts result
- x_result_id_o  out  ID_WIDTH  result ID
- x_result_rd_o  out  5  destination register
- x_result_data_o  out  DATA_WIDTH  result data
- x_result_we_o  out  1  register write enable
- overflow_o  out  1  sticky: CSR pulse lost to a full FIFO

Behaviour:
- Reset (asynchronous):
  - FIFO pointers and count = 0.
  - Output register invalid: x_result_valid_o=0; id, rd, data = 0; x_result_we_o=0.
  - rr_q=0 (CSR favoured first).
  - overflow_o=0, csr_afull_o=0, fpu_int_ready_o=0.
  - Reset mid-transfer discards all buffered results.
- CSR FIFO:
  - Push on csr_wb_i. Pop when the CSR side is granted and the output register loads.
  - Push and pop in the same cycle leave the count unchanged. Push while full is legal in that case.
  - Push when full with no pop: entry dropped, FIFO unchanged, overflow_o set until reset.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - csr_afull_o = (count >= DEPTH-1), registered-count based. This covers the one-cycle gap between instruction pop and csr_wb_i.
- Output register (single stage):
  - load = !x_result_valid_o || x_result_ready_i (full throughput on back-to-back accepts).
  - On load with a grant: capture the granted source's id, rd and data; set valid=1 and we=1.
  - On load with no grant: valid=0, we=0; data fields hold their old value.
  - While valid && !ready, all x_result_* outputs stay stable (core-interface rule).
- Arbitration (combinational, evaluated only when load=1):
  - csr_pend = count!=0; fpu_pend = fpu_int_valid_i.
  - Only one pending: grant it.
  - Both pending: grant CSR if rr_q=0, else FPU; rr_q toggles to favour the other source after every both-pending grant.
  - fpu_int_ready_o = load && FPU granted. It may depend combinationally on x_result_ready_i. FPU fields are sampled only on valid&&ready.
- Latency:
  - CSR: csr_wb_i in cycle N -> x_result_valid_o in cycle N+2 (FIFO write, then output load).
  - FPU: accept in cycle N -> x_result_valid_o in cycle N+1.
- Ordering:
  - CSR results leave in push order.
  - No ordering is imposed between CSR and FPU results; the core matches results by ID.
- Throughput: one result per cycle when x_result_ready_i is held high.

Decomposition:
- Package fpu_ss_pkg:
  - int_wb_t struct {id, rd, data} shared by the FIFO entry, the output register and the CSR-unit interface.
  - Constant FPU_SS_RD_W=5.
- Sub-module fpu_ss_wb_fifo: generic synchronous FIFO with entry type parameter, DEPTH, and count/full/empty outputs. Instantiated once for the CSR path; reusable elsewhere.
- Arbiter and output register stay inline.

Test Plan:
- CSR only: csr_wb_i at cycle 3 (id=5, rd=10, data=0x000000E0), ready=1 -> valid at cycle 5 with matching fields; FIFO empty afterwards.
- FPU only under backpressure: fpu valid (id=2, rd=7, data=0xDEADBEEF), ready=0 for 4 cycles -> fpu_int_ready_o high only at the load; outputs held stable for 4 cycles, then accepted once.
- Contention: FIFO holding 2 CSR entries plus a continuous FPU stream, ready=1 -> grants alternate CSR, FPU, CSR, FPU; rr_q toggles each time.
- Almost full: with ready=0 and one CSR entry queued, csr_afull_o=1; a second pulse fills the FIFO without overflow; a third pulse -> overflow_o=1, and only the first two IDs are ever delivered.
- Simultaneous push/pop at full (DEPTH=2), ready=1, pulse every cycle -> count stays 2, no overflow, IDs delivered in order.
- Reset asserted with the output valid and the FIFO holding 1 entry -> all outputs 0 immediately; after release, no stale result appears.
